// File: rtl/awg_pkg.sv
// Shared types and helpers for the AWG playback engine.
package awg_pkg;

  typedef enum logic [1:0] {StIdle, StPrime, StRun, StDrain} state_e;

  localparam int unsigned FracWDef    = 24;
  localparam logic [13:0] MidscaleDef = 14'h2000;

  // Table length must be 1..max_len and the step's integer part must stay below it,
  // so a single subtraction always brings the accumulator back into range.
  function automatic logic cfg_legal(input logic [15:0] len, input logic [15:0] max_len,
                                     input logic [15:0] step_int, input logic step_nz);
    return (len != 16'd0) && (len <= max_len) && step_nz && (step_int < len);
  endfunction

endpackage

// File: rtl/awg_phase_acc.sv
// Fractional phase accumulator with modulo-length wrap and registered wrap pulse.
module awg_phase_acc #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned FRAC_W = 24
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     advance_i,
  input  logic [ADDR_W:0]          len_i,
  input  logic [ADDR_W+FRAC_W-1:0] step_i,
  output logic [ADDR_W-1:0]        addr_o,
  output logic                     wrap_o,
  output logic                     wrap_pulse_o
);

  localparam int unsigned AccW = ADDR_W + FRAC_W;

  logic [AccW:0]   sum;
  logic [AccW-1:0] sum_wrapped;
  logic [AccW-1:0] acc_q, acc_d;
  logic            wrap_q, wrap_d;

  // One extra bit so acc + step never overflows before the length compare.
  assign sum         = {1'b0, acc_q} + {1'b0, step_i};
  assign wrap_o      = (sum[AccW:FRAC_W] >= len_i);
  // Modulo 2^AccW the top length bit drops out, so only the low ADDR_W bits matter.
  assign sum_wrapped = sum[AccW-1:0] - {len_i[ADDR_W-1:0], {FRAC_W{1'b0}}};

  always_comb begin
    acc_d  = acc_q;
    wrap_d = 1'b0;
    if (clear_i) begin
      acc_d = '0;
    end else if (advance_i) begin
      acc_d  = wrap_o ? sum_wrapped : sum[AccW-1:0];
      wrap_d = wrap_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      wrap_q <= wrap_d;
    end
  end

  assign addr_o       = acc_q[AccW-1:FRAC_W];
  assign wrap_pulse_o = wrap_q;

endmodule

// File: rtl/awg_playback.sv
// Waveform playback engine: walks the waveform RAM with a fractional phase
// accumulator and drives the AD9744 data word every clock.
module awg_playback
  import awg_pkg::*;
#(
  parameter int unsigned       DATA_W   = 14,
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       FRAC_W   = FracWDef,
  parameter logic [DATA_W-1:0] MIDSCALE = MidscaleDef
) (
  input  logic                     clk_AD9744,
  input  logic                     rst,
  input  logic                     cfg_valid,
  input  logic [ADDR_W:0]          cfg_len,
  input  logic [ADDR_W+FRAC_W-1:0] cfg_step,
  input  logic                     run,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        rd_data,
  output logic [DATA_W-1:0]        wd,
  output logic                     wd_valid,
  output logic                     busy,
  output logic                     wrap_pulse,
  output logic                     cfg_err
);

  localparam int unsigned     AccW      = ADDR_W + FRAC_W;
  localparam logic [ADDR_W:0] LenMax    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [AccW-1:0] StepUnity = {{(ADDR_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};

  state_e              state_q, state_d;
  logic [ADDR_W:0]     len_q;
  logic [AccW-1:0]     step_q;
  logic                cfg_ok;
  logic                cfg_err_q;
  logic [1:0]          tail_q, tail_d;
  logic                rd_en_q, rd_en_d;
  logic                rd_vld_q;
  logic [DATA_W-1:0]   wd_q, wd_d;
  logic                wd_valid_q, wd_valid_d;
  logic                acc_clear, acc_advance, acc_wrap;

  assign cfg_ok = (state_q == StIdle) &&
                  cfg_legal(16'(cfg_len), 16'(LenMax), 16'(cfg_step[AccW-1:FRAC_W]),
                            |cfg_step);

  awg_phase_acc #(
    .ADDR_W(ADDR_W),
    .FRAC_W(FRAC_W)
  ) u_phase_acc (
    .clk_i       (clk_AD9744),
    .rst_i       (rst),
    .clear_i     (acc_clear),
    .advance_i   (acc_advance),
    .len_i       (len_q),
    .step_i      (step_q),
    .addr_o      (rd_addr),
    .wrap_o      (acc_wrap),
    .wrap_pulse_o(wrap_pulse)
  );

  // tail_q counts down the two cycles after the final read in DRAIN.
  assign acc_advance = (state_q == StPrime) || (state_q == StRun) ||
                       ((state_q == StDrain) && (tail_q == 2'd0));
  assign acc_clear   = (state_d == StIdle);

  always_ff @(posedge clk_AD9744 or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (run) state_d = StPrime;
      StPrime: state_d = StRun;
      StRun:   if (!run) state_d = StDrain;
      StDrain: begin
        if (tail_q == 2'd0) begin
          if (run) state_d = StRun;
        end else if (tail_q == 2'd1) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tail_d = tail_q;
    if ((state_q == StDrain) && (tail_q == 2'd0) && !run && acc_wrap) begin
      tail_d = 2'd2;
    end else if (tail_q != 2'd0) begin
      tail_d = tail_q - 2'd1;
    end
    rd_en_d = (state_d == StPrime) || (state_d == StRun) ||
              ((state_d == StDrain) && (tail_d == 2'd0));
    wd_d       = wd_q;
    wd_valid_d = wd_valid_q;
    if (rd_vld_q) begin
      wd_d       = rd_data;
      wd_valid_d = 1'b1;
    end else if (state_d == StIdle) begin
      wd_d       = MIDSCALE;
      wd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_AD9744 or posedge rst) begin
    if (rst) begin
      len_q      <= LenMax;
      step_q     <= StepUnity;
      cfg_err_q  <= 1'b0;
      tail_q     <= 2'd0;
      rd_en_q    <= 1'b0;
      rd_vld_q   <= 1'b0;
      wd_q       <= MIDSCALE;
      wd_valid_q <= 1'b0;
    end else begin
      if (cfg_valid && cfg_ok) begin
        len_q  <= cfg_len;
        step_q <= cfg_step;
      end
      cfg_err_q  <= cfg_valid && !cfg_ok;
      tail_q     <= tail_d;
      rd_en_q    <= rd_en_d;
      rd_vld_q   <= rd_en_q;
      wd_q       <= wd_d;
      wd_valid_q <= wd_valid_d;
    end
  end

  assign rd_en    = rd_en_q;
  assign wd       = wd_q;
  assign wd_valid = wd_valid_q;
  assign busy     = (state_q != StIdle);
  assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_awg_playback.sv
// Directed bench for awg_playback with a 1-cycle-latency RAM holding sample[i] = i*64.
module tb_awg_playback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic [8:0]  cfg_len = '0;
  logic [31:0] cfg_step = '0;
  logic        run = 1'b0;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [13:0] rd_data = '0;
  logic [13:0] wd;
  logic        wd_valid, busy, wrap_pulse, cfg_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= {rd_addr, 6'b0};

  awg_playback dut (
    .clk_AD9744(clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_len   (cfg_len),
    .cfg_step  (cfg_step),
    .run       (run),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wd        (wd),
    .wd_valid  (wd_valid),
    .busy      (busy),
    .wrap_pulse(wrap_pulse),
    .cfg_err   (cfg_err)
  );

  // Waits (bounded) for busy to drop; returns 1 on timeout.
  task automatic wait_idle(output bit timeout);
    timeout = 1'b1;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (!busy) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks += 7;
    if (wd !== 14'h2000) begin n_fail++; $display("FAIL reset_wd got %h exp 2000", wd); end
    if (wd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wd_valid got %b exp 0", wd_valid); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got %b exp 0", rd_en); end
    if (rd_addr !== 8'd0) begin n_fail++; $display("FAIL reset_rd_addr got %0d exp 0", rd_addr); end
    if (wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got %b exp 0", wrap_pulse); end
    if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_err got %b exp 0", cfg_err); end
  endtask

  task automatic test_unity;
    bit to;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_len = 9'd256; cfg_step = 32'h0100_0000;
    @(negedge clk);
    cfg_valid = 1'b0;
    n_checks++;
    if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL unity_cfg_err got %b exp 0", cfg_err); end
    run = 1'b1;
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      n_checks += 4;
      if (rd_addr !== 8'(j % 256)) begin
        n_fail++; $display("FAIL unity_addr j=%0d got %0d exp %0d", j, rd_addr, j % 256);
      end
      if (wrap_pulse !== (j > 0 && j % 256 == 0)) begin
        n_fail++; $display("FAIL unity_wrap j=%0d got %b", j, wrap_pulse);
      end
      if (wd_valid !== (j >= 2)) begin
        n_fail++; $display("FAIL unity_valid j=%0d got %b exp %b", j, wd_valid, j >= 2);
      end
      if (wd !== ((j >= 2) ? 14'(((j - 2) % 256) * 64) : 14'h2000)) begin
        n_fail++; $display("FAIL unity_wd j=%0d got %0d", j, wd);
      end
    end
    run = 1'b0;
    wait_idle(to);
    n_checks += 2;
    if (to) begin n_fail++; $display("FAIL unity_stop busy=%b exp 0", busy); end
    if (wd !== 14'h2000) begin n_fail++; $display("FAIL unity_idle_wd got %h exp 2000", wd); end
  endtask

  task automatic test_frac_step;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_len = 9'd100; cfg_step = 32'h0280_0000;
    @(negedge clk);
    cfg_valid = 1'b0;
    n_checks++;
    if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL frac_cfg_err got %b exp 0", cfg_err); end
    run = 1'b1;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      n_checks += 3;
      if (rd_addr !== 8'((5 * (j % 40)) / 2)) begin
        n_fail++; $display("FAIL frac_addr j=%0d got %0d exp %0d", j, rd_addr, (5 * (j % 40)) / 2);
      end
      if (wrap_pulse !== (j > 0 && j % 40 == 0)) begin
        n_fail++; $display("FAIL frac_wrap j=%0d got %b", j, wrap_pulse);
      end
      if (j >= 2 && wd !== 14'(((5 * ((j - 2) % 40)) / 2) * 64)) begin
        n_fail++; $display("FAIL frac_wd j=%0d got %0d", j, wd);
      end
    end
  endtask

  // Continues the len=100, step=2.5 run; a config write mid-run must be rejected.
  task automatic test_cfg_in_run;
    bit to;
    for (int j = 100; j < 180; j++) begin
      @(negedge clk);
      n_checks += 3;
      if (rd_addr !== 8'((5 * (j % 40)) / 2)) begin
        n_fail++; $display("FAIL run_cfg_addr j=%0d got %0d exp %0d", j, rd_addr, (5 * (j % 40)) / 2);
      end
      if (wrap_pulse !== (j % 40 == 0)) begin
        n_fail++; $display("FAIL run_cfg_wrap j=%0d got %b", j, wrap_pulse);
      end
      if (cfg_err !== (j == 121)) begin
        n_fail++; $display("FAIL run_cfg_err j=%0d got %b exp %b", j, cfg_err, j == 121);
      end
      if (j == 120) begin
        cfg_valid = 1'b1; cfg_len = 9'd50; cfg_step = 32'h0280_0000;
      end
      if (j == 121) cfg_valid = 1'b0;
    end
    run = 1'b0;
    wait_idle(to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL run_cfg_stop busy=%b exp 0", busy); end
  endtask

  // Config and run in the same cycle, then drop run at address 30.
  task automatic test_drain;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_len = 9'd100; cfg_step = 32'h0100_0000; run = 1'b1;
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    for (int j = 0; j < 104; j++) begin
      @(negedge clk);
      n_checks += 6;
      if (rd_addr !== ((j <= 99) ? 8'(j) : 8'd0)) begin
        n_fail++; $display("FAIL drain_addr j=%0d got %0d", j, rd_addr);
      end
      if (rd_en !== (j <= 99)) begin
        n_fail++; $display("FAIL drain_rd_en j=%0d got %b exp %b", j, rd_en, j <= 99);
      end
      if (wrap_pulse !== (j == 100)) begin
        n_fail++; $display("FAIL drain_wrap j=%0d got %b exp %b", j, wrap_pulse, j == 100);
      end
      if (wd_valid !== (j >= 2 && j <= 101)) begin
        n_fail++; $display("FAIL drain_valid j=%0d got %b", j, wd_valid);
      end
      if (wd !== ((j >= 2 && j <= 101) ? 14'((j - 2) * 64) : 14'h2000)) begin
        n_fail++; $display("FAIL drain_wd j=%0d got %0d", j, wd);
      end
      if (busy !== (j <= 101)) begin
        n_fail++; $display("FAIL drain_busy j=%0d got %b exp %b", j, busy, j <= 101);
      end
      if (j == 30) run = 1'b0;
    end
  endtask

  task automatic test_cfg_reject_and_reset;
    bit to;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_len = 9'd0; cfg_step = 32'h0100_0000;
    @(negedge clk);
    n_checks++;
    if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL rej_len0 got %b exp 1", cfg_err); end
    cfg_len = 9'd10; cfg_step = 32'h0A00_0000;
    @(negedge clk);
    n_checks++;
    if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL rej_step got %b exp 1", cfg_err); end
    cfg_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL rej_clear got %b exp 0", cfg_err); end
    // Registers must still hold len=100, step=1.0 from the previous write.
    run = 1'b1;
    for (int j = 0; j < 105; j++) begin
      @(negedge clk);
      n_checks += 2;
      if (rd_addr !== 8'(j % 100)) begin
        n_fail++; $display("FAIL rej_addr j=%0d got %0d exp %0d", j, rd_addr, j % 100);
      end
      if (wrap_pulse !== (j == 100)) begin
        n_fail++; $display("FAIL rej_wrap j=%0d got %b exp %b", j, wrap_pulse, j == 100);
      end
    end
    rst = 1'b1;
    run = 1'b0;
    #1;
    n_checks += 6;
    if (wd !== 14'h2000) begin n_fail++; $display("FAIL rst_wd got %h exp 2000", wd); end
    if (wd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", wd_valid); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    if (rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en got %b exp 0", rd_en); end
    if (rd_addr !== 8'd0) begin n_fail++; $display("FAIL rst_rd_addr got %0d exp 0", rd_addr); end
    if (wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL rst_wrap got %b exp 0", wrap_pulse); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Reset restores len=256: no wrap at 100, first wrap at 256.
    run = 1'b1;
    for (int j = 0; j < 260; j++) begin
      @(negedge clk);
      n_checks += 2;
      if (rd_addr !== 8'(j % 256)) begin
        n_fail++; $display("FAIL rst_len_addr j=%0d got %0d exp %0d", j, rd_addr, j % 256);
      end
      if (wrap_pulse !== (j == 256)) begin
        n_fail++; $display("FAIL rst_len_wrap j=%0d got %b exp %b", j, wrap_pulse, j == 256);
      end
    end
    run = 1'b0;
    wait_idle(to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL final_stop busy=%b exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_unity();
    test_frac_step();
    test_cfg_in_run();
    test_drain();
    test_cfg_reject_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
